// File: rtl/seq_hit_fifo_if.sv
// Handshake bundle for seq_hit_fifo: hit/clr inputs, timestamp drain port and statistics.
interface seq_hit_fifo_if #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             hit;
  logic             clr;
  logic             out_valid;
  logic             out_ready;
  logic [TS_W-1:0]  out_ts;
  logic [LVL_W-1:0] level;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] drop_count;
  logic             overflow;

  modport master (
    output hit, clr, out_ready,
    input  out_valid, out_ts, level, hit_count, drop_count, overflow
  );

  modport slave (
    input  hit, clr, out_ready,
    output out_valid, out_ts, level, hit_count, drop_count, overflow
  );
endinterface

// File: rtl/seq_hit_fifo.sv
// Timestamps each match pulse against a free-running counter and buffers the stamps in a
// small FIFO drained over valid/ready; keeps saturating hit/drop counts and a sticky overflow.
module seq_hit_fifo #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         reset,
  seq_hit_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [TS_W-1:0]  mem_q [DEPTH];
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [TS_W-1:0]  head_q, head_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, drop_cnt_q, drop_cnt_d;
  logic             ovf_q, ovf_d;
  logic             pop_s, push_s, drop_s, full_s;

  // Next-state: push/pop bookkeeping, registered head prefetch, saturating statistics.
  always_comb begin
    full_s     = (level_q == LVL_W'(DEPTH));
    pop_s      = (level_q != {LVL_W{1'b0}}) && bus.out_ready && !bus.clr;
    push_s     = bus.hit && !bus.clr && (!full_s || pop_s);
    drop_s     = bus.hit && !bus.clr && full_s && !pop_s;
    ts_d       = ts_q + TS_W'(1);
    rd_d       = pop_s  ? rd_q + PTR_W'(1) : rd_q;
    wr_d       = push_s ? wr_q + PTR_W'(1) : wr_q;
    level_d    = level_q;
    hit_cnt_d  = hit_cnt_q;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;
    if (push_s && !pop_s) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop_s && !push_s) begin
      level_d = level_q - LVL_W'(1);
    end else begin
      level_d = level_q;
    end
    if (bus.hit && (hit_cnt_q != {CNT_W{1'b1}})) begin
      hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end else begin
      hit_cnt_d = hit_cnt_q;
    end
    if (drop_s) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != {CNT_W{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end else begin
      ovf_d = ovf_q;
    end
    if (bus.clr) begin
      ts_d       = {TS_W{1'b0}};
      rd_d       = {PTR_W{1'b0}};
      wr_d       = {PTR_W{1'b0}};
      level_d    = {LVL_W{1'b0}};
      hit_cnt_d  = {CNT_W{1'b0}};
      drop_cnt_d = {CNT_W{1'b0}};
      ovf_d      = 1'b0;
    end else begin
      ts_d = ts_d;
    end
    // When the new head is the entry being written this edge, take it from the counter.
    valid_d = (level_d != {LVL_W{1'b0}});
    if (!valid_d) begin
      head_d = {TS_W{1'b0}};
    end else if (push_s && ((level_q == {LVL_W{1'b0}}) ||
                            ((level_q == LVL_W'(1)) && pop_s))) begin
      head_d = ts_q;
    end else begin
      head_d = mem_q[rd_d];
    end
  end

  // State registers, FIFO storage and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {TS_W{1'b0}};
      end
      ts_q       <= {TS_W{1'b0}};
      rd_q       <= {PTR_W{1'b0}};
      wr_q       <= {PTR_W{1'b0}};
      level_q    <= {LVL_W{1'b0}};
      head_q     <= {TS_W{1'b0}};
      valid_q    <= 1'b0;
      hit_cnt_q  <= {CNT_W{1'b0}};
      drop_cnt_q <= {CNT_W{1'b0}};
      ovf_q      <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_q] <= ts_q;
      end
      ts_q       <= ts_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      level_q    <= level_d;
      head_q     <= head_d;
      valid_q    <= valid_d;
      hit_cnt_q  <= hit_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_ts     = head_q;
  assign bus.level      = level_q;
  assign bus.hit_count  = hit_cnt_q;
  assign bus.drop_count = drop_cnt_q;
  assign bus.overflow   = ovf_q;
endmodule
